// File: rtl/rca_seq_addsub.sv
// ---------------------------------------------------------------------------
// rca_seq_addsub
//   Multi-cycle add/subtract sequencer. Wide operands are pushed through a
//   single 8-bit ripple-carry byte adder, one byte per clock, LSB first. The
//   carry is chained between bytes. The final result and flags are latched
//   and held until the next accepted request.
//
// Parameters
//   NBYTES    operand width in bytes (W = 8*NBYTES), legal range 2..16
//
// Ports
//   clk       in   1   system clock, rising edge
//   rst       in   1   asynchronous, active-high reset
//   start     in   1   request; accepted only while ready = 1
//   op        in   1   0 = A+B, 1 = A-B; sampled with start
//   A         in   W   operand A; sampled with start
//   B         in   W   operand B; sampled with start
//   ready     out  1   a new start can be accepted (state != RUN)
//   done      out  1   one-cycle pulse; result and flags are valid
//   result    out  W   A+B or A-B, modulo 2^W
//   cout      out  1   carry out of the MSB (sub: 1 = no borrow)
//   overflow  out  1   signed overflow (carry into MSB XOR carry out)
//   zero      out  1   result == 0
// ---------------------------------------------------------------------------
module rca_seq_addsub #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  op,
  input  logic [8*NBYTES-1:0]   A,
  input  logic [8*NBYTES-1:0]   B,
  output logic                  ready,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic                  cout,
  output logic                  overflow,
  output logic                  zero
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   idx_q;
  logic            carry_q;
  logic            op_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    result_q;
  logic            ready_q;
  logic            done_q;
  logic            cout_q;
  logic            overflow_q;
  logic            zero_q;

  // Byte-datapath signals computed from the current byte index.
  logic [IW+2:0]   bit_base_s;
  logic [7:0]      a_byte_s;
  logic [7:0]      b_byte_s;
  logic [7:0]      bx_byte_s;
  logic [8:0]      sum_s;
  logic            msb_cin_s;
  logic [W-1:0]    result_d;
  logic            zero_d;

  // Byte adder: selects the active operand bytes, conditionally inverts B,
  // and forms the 9-bit sum plus the result vector with the new byte merged in.
  always_comb begin
    bit_base_s = {idx_q, 3'b000};
    a_byte_s   = a_q[bit_base_s +: 8];
    b_byte_s   = b_q[bit_base_s +: 8];
    if (op_q) begin
      bx_byte_s = ~b_byte_s;
    end else begin
      bx_byte_s = b_byte_s;
    end
    sum_s = {1'b0, a_byte_s} + {1'b0, bx_byte_s} + {8'd0, carry_q};
    // Carry into bit 7 of this byte is recovered from the sum bit: s = a ^ b ^ cin.
    msb_cin_s = a_byte_s[7] ^ bx_byte_s[7] ^ sum_s[7];
    result_d  = result_q;
    result_d[bit_base_s +: 8] = sum_s[7:0];
    // Zero must include the byte being written on this edge.
    zero_d = (result_d == {W{1'b0}});
  end

  // Sequencer FSM with registered status and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      op_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_q        <= A;
            b_q        <= B;
            op_q       <= op;
            // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
            carry_q    <= op;
            idx_q      <= '0;
            result_q   <= '0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            state_q    <= S_RUN;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
          end else begin
            state_q    <= S_IDLE;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
          end
        end
        S_RUN: begin
          result_q <= result_d;
          carry_q  <= sum_s[8];
          if (idx_q == LAST_IDX) begin
            idx_q      <= '0;
            cout_q     <= sum_s[8];
            overflow_q <= msb_cin_s ^ sum_s[8];
            zero_q     <= zero_d;
            state_q    <= S_DONE;
            ready_q    <= 1'b1;
            done_q     <= 1'b1;
          end else begin
            idx_q      <= idx_q + {{(IW-1){1'b0}}, 1'b1};
            state_q    <= S_RUN;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          idx_q   <= '0;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready    = ready_q;
  assign done     = done_q;
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_rca_seq_addsub.sv
module tb_rca_seq_addsub;

  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  logic          clk;
  logic          rst;
  logic          start;
  logic          op;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          ready;
  logic          done;
  logic [W-1:0]  result;
  logic          cout;
  logic          overflow;
  logic          zero;

  int n_checks;
  int n_fail;

  typedef struct packed {
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
    logic         zero;
  } exp_t;

  rca_seq_addsub #(.NBYTES(NBYTES)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .A        (A),
    .B        (B),
    .ready    (ready),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: whole-word arithmetic, signed overflow from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic o);
    exp_t         e;
    logic [W-1:0] bx;
    logic [W:0]   full;
    bx     = o ? ~b : b;
    full   = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, o};
    e.res  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (a[W-1] == bx[W-1]) && (full[W-1] != a[W-1]);
    e.zero = (full[W-1:0] == '0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_flags(input string tag, input exp_t e);
    chk({tag, " result"}, 64'(result), 64'(e.res));
    chk({tag, " cout"}, 64'(cout), 64'(e.cout));
    chk({tag, " overflow"}, 64'(overflow), 64'(e.ovf));
    chk({tag, " zero"}, 64'(zero), 64'(e.zero));
  endtask

  // Called just after a negedge with the DUT ready. Returns just after the
  // negedge on which done must be high. glitch_at >= 0 pulses start with
  // scrambled operands while the operation is running.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic o,
                        input int glitch_at, input string tag);
    exp_t e;
    e = model(a, b, o);
    chk({tag, " ready before start"}, 64'(ready), 64'd1);
    A = a; B = b; op = o; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    A = $urandom; B = $urandom; op = ~o;
    chk({tag, " ready in run"}, 64'(ready), 64'd0);
    for (int k = 1; k <= NBYTES; k++) begin
      if (k - 1 == glitch_at) begin
        start = 1'b1;
        A = $urandom; B = $urandom;
      end
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      if (k < NBYTES) begin
        chk({tag, " done early"}, 64'(done), 64'd0);
      end else begin
        chk({tag, " done on time"}, 64'(done), 64'd1);
        chk({tag, " ready at done"}, 64'(ready), 64'd1);
      end
    end
    check_flags(tag, e);
  endtask

  initial begin
    exp_t e;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; start = 1'b0; op = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst ready", 64'(ready), 64'd1);
    chk("rst done", 64'(done), 64'd0);
    chk("rst result", 64'(result), 64'd0);
    chk("rst cout", 64'(cout), 64'd0);
    chk("rst overflow", 64'(overflow), 64'd0);
    chk("rst zero", 64'(zero), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, -1, "t1 add carry");
    @(negedge clk);
    chk("t1 done one cycle", 64'(done), 64'd0);
    chk("t1 result held", 64'(result), 64'h0000_0100);
    run_op(32'h0000_0000, 32'h0000_0001, 1'b1, -1, "t2 sub borrow");
    @(negedge clk);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, -1, "t3 add ovf");
    @(negedge clk);
    run_op(32'h1234_5678, 32'h1234_5678, 1'b1, -1, "t4 sub zero");
    @(negedge clk);

    // Back-to-back: second start held during DONE is accepted
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, -1, "t5a wrap");
    chk("t5a result literal", 64'(result), 64'd0);
    chk("t5a cout literal", 64'(cout), 64'd1);
    run_op(32'h0000_0005, 32'h0000_0003, 1'b1, -1, "t5b b2b sub");
    chk("t5b result literal", 64'(result), 64'd2);
    @(negedge clk);

    // Start pulses during RUN are ignored
    for (int g = 0; g < NBYTES; g++) begin
      run_op(32'hA5A5_0F0F + 32'(g), 32'h5A5A_F0F1, g[0], g, "glitch");
      @(negedge clk);
    end

    // Start during RUN then reset mid-operation: abandoned, no done
    A = 32'h0102_0304; B = 32'h1111_1111; op = 1'b0; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    @(posedge clk); @(negedge clk);
    start = 1'b1; A = 32'hDEAD_BEEF; B = 32'h0000_0001;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    chk("t6 still running", 64'(ready), 64'd0);
    rst = 1'b1;
    #1;
    chk("t6 rst ready", 64'(ready), 64'd1);
    chk("t6 rst result", 64'(result), 64'd0);
    chk("t6 rst cout", 64'(cout), 64'd0);
    chk("t6 rst overflow", 64'(overflow), 64'd0);
    chk("t6 rst zero", 64'(zero), 64'd0);
    chk("t6 rst done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < NBYTES + 3; k++) begin
      @(negedge clk);
      chk("t6 no done after rst", 64'(done), 64'd0);
    end

    // Random operations with random idle gaps, glitches and back-to-back starts
    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         ro;
      int           gap;
      int           gl;
      ra = $urandom; rb = $urandom; ro = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: ra = 32'h8000_0000;
        default: ;
      endcase
      gl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NBYTES - 1)) : -1;
      e  = model(ra, rb, ro);
      run_op(ra, rb, ro, gl, "rand");
      gap = $urandom_range(0, 2);
      for (int k = 0; k < gap; k++) begin
        @(negedge clk);
        chk("rand idle done", 64'(done), 64'd0);
        chk("rand hold result", 64'(result), 64'(e.res));
        chk("rand hold zero", 64'(zero), 64'(e.zero));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
